// File: rtl/ping_pong_ctrl.sv
// Sequencing controller for the ping-pong counter: range capture and check, prescaled
// count strobes, flip alignment. Optional auto-stop on reversals: `PPC_AUTO_STOP_EN`.
module ping_pong_ctrl #(
    parameter int unsigned DIV          = 25_000_000,
    parameter int unsigned DIV_W        = 25,
    parameter int unsigned BOUNCE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_start,
    input  logic       btn_flip,
    input  logic [3:0] sw,
    input  logic       cnt_dir,
    output logic [3:0] cnt_min,
    output logic [3:0] cnt_max,
    output logic       cnt_load,
    output logic       cnt_enable,
    output logic       cnt_flip,
    output logic [2:0] state,
    output logic       err,
    output logic       done
);

    typedef enum logic [2:0] {
        CFG_MIN = 3'd0,
        CFG_MAX = 3'd1,
        CHECK   = 3'd2,
        LOAD    = 3'd3,
        RUN     = 3'd4,
        PAUSE   = 3'd5,
        ERR     = 3'd6
    } state_t;

    localparam logic [DIV_W-1:0] PRESC_LAST    = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] PRESC_PRELAST = DIV_W'(DIV - 2);

    state_t           state_q;
    logic [3:0]       min_q;
    logic [3:0]       max_q;
    logic [DIV_W-1:0] presc_q;
    logic             flip_pend_q;
    logic             load_q;
    logic             en_q;
    logic             err_q;
    logic             flip_ok;

    // A flip that shares its cycle with a state-changing button is dropped.
    assign flip_ok = btn_flip & ~btn_mode & ~btn_start;

`ifdef PPC_AUTO_STOP_EN
    localparam int unsigned      BW  = $clog2(BOUNCE_LIMIT + 1);
    localparam logic [BW-1:0]    LIM = BW'(BOUNCE_LIMIT);

    logic [BW-1:0] bounce_q;
    logic [BW-1:0] bounce_d;
    logic          dir_q;
    logic          done_q;
    logic          limit_hit;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        bounce_d  = bounce_q;
        limit_hit = 1'b0;
        if (en_q) begin
            if ((cnt_dir != dir_q) && (bounce_q != LIM)) begin
                bounce_d = bounce_q + 1'b1;
            end
            limit_hit = (bounce_d == LIM);
        end
    end
`else
    localparam int unsigned unused_bounce_limit = BOUNCE_LIMIT;
    logic unused_dir;
    assign unused_dir = cnt_dir;
`endif

    // NOTE: all state is written with non-blocking assignments so every register
    // sees the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CFG_MIN;
            min_q       <= '0;
            max_q       <= '0;
            presc_q     <= '0;
            flip_pend_q <= 1'b0;
            load_q      <= 1'b0;
            en_q        <= 1'b0;
            err_q       <= 1'b0;
`ifdef PPC_AUTO_STOP_EN
            bounce_q    <= '0;
            dir_q       <= 1'b1;
            done_q      <= 1'b0;
`endif
        end else begin
            load_q <= 1'b0;
            en_q   <= 1'b0;
`ifdef PPC_AUTO_STOP_EN
            done_q <= 1'b0;
            if (en_q) begin
                dir_q    <= cnt_dir;
                bounce_q <= bounce_d;
            end
`endif
            case (state_q)
                CFG_MIN: begin
                    if (btn_mode) begin
                        min_q   <= sw;
                        state_q <= CFG_MAX;
                    end
                end
                CFG_MAX: begin
                    if (btn_mode) begin
                        max_q   <= sw;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (max_q > min_q) begin
                        state_q <= LOAD;
                        load_q  <= 1'b1;
                    end else begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                end
                ERR: begin
                    if (btn_mode) begin
                        state_q <= CFG_MIN;
                        err_q   <= 1'b0;
                    end
                end
                LOAD: begin
                    state_q     <= RUN;
                    presc_q     <= '0;
                    flip_pend_q <= 1'b0;
`ifdef PPC_AUTO_STOP_EN
                    bounce_q    <= '0;
                    dir_q       <= 1'b1;
`endif
                end
                RUN: begin
                    presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
                    if (btn_mode) begin
                        state_q     <= CFG_MIN;
                        flip_pend_q <= 1'b0;
                    end else if (btn_start) begin
                        state_q     <= PAUSE;
                        flip_pend_q <= 1'b0;
`ifdef PPC_AUTO_STOP_EN
                    end else if (limit_hit) begin
                        state_q     <= PAUSE;
                        flip_pend_q <= 1'b0;
                        bounce_q    <= '0;
                        done_q      <= 1'b1;
`endif
                    end else begin
                        // The strobe lands when the incremented prescaler reaches DIV-1.
                        en_q        <= (presc_q == PRESC_PRELAST);
                        flip_pend_q <= en_q ? 1'b0 : (flip_pend_q | btn_flip);
                    end
                end
                PAUSE: begin
                    if (btn_mode) begin
                        state_q <= CFG_MIN;
                    end else if (btn_start) begin
                        state_q <= RUN;
                        en_q    <= (presc_q == PRESC_LAST);
                    end
                end
                default: begin
                    state_q <= CFG_MIN;
                end
            endcase
        end
    end

    assign cnt_min    = min_q;
    assign cnt_max    = max_q;
    assign cnt_load   = load_q;
    assign cnt_enable = en_q;
    assign cnt_flip   = en_q & (flip_pend_q | flip_ok);
    assign state      = state_q;
    assign err        = err_q;
`ifdef PPC_AUTO_STOP_EN
    assign done       = done_q;
`else
    assign done       = 1'b0;
`endif

endmodule
